game_ctrl_gen: RTL and testbench
================================

# game_ctrl_gen

Parametrised top-level game controller for the sliding-board puzzle. It owns the game phase FSM. It turns the raw set and action buttons into one-cycle pulses. It counts moves and elapsed seconds, and enforces optional move and time limits through a new LOST phase. It sits between the player I/O and the board-loader / play-engine blocks, and muxes their display buses onto one registered output.

## Interface
Parameters:
- ACT_N, 4, number of action buttons.
- OUT_W, 12, display bus width.
- STEP_W, 6, move counter width.
- TIME_W, 8, seconds counter width.
- TICK_DIV, 100, clk_d cycles per one-second tick (≥2).
- STEP_LIMIT, 0, move limit (0 = unlimited).
- TIME_LIMIT, 0, time limit in seconds (0 = unlimited).

Ports:
- clk_d  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_sw  in  1  level; 1 = play, 0 = return to board selection.
- set_bt  in  1  raw board-set button level.
- act_bt  in  ACT_N  raw action button levels.
- win_flag  in  1  from play engine; board solved.
- init_done  in  1  from board loader; board loaded into play engine.
- out_mode_chose  in  OUT_W  display bus from board loader.
- out_mode_game  in  OUT_W  display bus from play engine.
- set_pulse  out  1  one-cycle set pulse, only in CHOSE_BOARD.
- act_pulse  out  ACT_N  one-hot one-cycle move pulse, only in GAMING.
- game_status  out  3  current phase code.
- step_count  out  STEP_W  valid moves this game.
- time_sec  out  TIME_W  seconds elapsed in GAMING.
- out  out  OUT_W  registered display output.

## Operation
- Phase codes:
  - CHOSE_BOARD = 000
  - GAMING = 001
  - GAME_INITIAL = 010
  - WINNED = 011
  - LOST = 100
- Button edge detection, per button: a sample register b_q, reset to 1.
  - Raw pulse is registered as b & ~b_q.
  - A button held through reset produces no pulse.
  - Holding a button produces exactly one pulse.
- Chord rejection: the act raw pulse vector is forwarded only if exactly one bit is set. Zero or ≥2 bits give all-zero output and no step is counted.
- act_pulse = filtered vector AND (state==GAMING). set_pulse = raw set pulse AND (state==CHOSE_BOARD).
- Transitions, evaluated each clock. start_sw==0 has top priority in every state except CHOSE_BOARD.
  - CHOSE_BOARD: start_sw=1 → GAME_INITIAL. On that edge, clear step_count, time_sec and the prescaler.
  - GAME_INITIAL: start_sw=0 → CHOSE_BOARD; else init_done=1 → GAMING.
  - GAMING: start_sw=0 → CHOSE_BOARD; else win_flag=1 → WINNED; else limit hit → LOST.
    - Limit hit: (STEP_LIMIT≠0 and step_count≥STEP_LIMIT) or (TIME_LIMIT≠0 and time_sec≥TIME_LIMIT).
  - WINNED, LOST: hold; start_sw=0 → CHOSE_BOARD.
- Step counter:
  - In GAMING, each valid one-hot pulse increments it, saturating at 2^STEP_W−1.
  - A pulse in the same cycle as win_flag or a limit transition is still counted.
  - Frozen in every other state. Retains its value in CHOSE_BOARD until the next start.
- Time base:
  - The prescaler counts 0..TICK_DIV−1 only in GAMING.
  - At TICK_DIV−1 it wraps to 0 and time_sec increments, saturating at 2^TIME_W−1.
  - Frozen outside GAMING.
- Output mux: out <= (state==CHOSE_BOARD) ? out_mode_chose : out_mode_game, selected by the registered state.

## Timing
- Reset values:
  - state = CHOSE_BOARD
  - set_pulse = 0, act_pulse = 0
  - step_count = 0, time_sec = 0, out = 0
  - prescaler = 0, all b_q = 1
- Pulse latency: a button sampled high at edge k (low at k−1) gives a pulse in cycle k+1..k+2, i.e. asserted after edge k+1, one cycle wide. step_count updates at the edge that ends the pulse cycle.
- State changes are one cycle after the qualifying input is sampled. game_status is the state register, with no extra delay.
- out lags its source bus and the state by one cycle.
- LOST on the step limit is entered one clock after step_count reaches STEP_LIMIT. LOST on the time limit is entered one clock after time_sec reaches TIME_LIMIT.
- Reset mid-game returns to CHOSE_BOARD on the next edge, with counters zeroed.

## Test plan
- Reset with act_bt[0] held, then run 10 cycles → no act_pulse, state=000, out=0.
- start_sw=1, init_done high 3 cycles later → states 000→010→001. Press act_bt[2] for 5 cycles → act_pulse=0100 for exactly one cycle, step_count=1.
- In GAMING, press act_bt[0] and act_bt[1] on the same edge → act_pulse stays 0, step_count unchanged.
- STEP_LIMIT=3: three valid presses → step_count=3, then game_status=100 one cycle later. Further presses give no pulse and the count stays 3.
- TICK_DIV=4, TIME_LIMIT=2: in GAMING → time_sec=1 after 4 cycles, 2 after 8, LOST on the 9th edge. Assert win_flag in the same cycle a limit is hit → WINNED (011).
- From WINNED, start_sw=0 → CHOSE_BOARD. out switches to out_mode_chose one cycle later. step_count holds until the next start_sw=1 clears it.

Source files
------------

// File: rtl/game_ctrl_gen.sv
// game_ctrl_gen: top-level controller for the sliding-board puzzle.
// Owns the game phase FSM, turns raw buttons into one-cycle pulses, counts
// moves and seconds, enforces optional move/time limits and muxes the
// loader / engine display buses onto one registered output.
module game_ctrl_gen #(
  parameter int ACT_N      = 4,
  parameter int OUT_W      = 12,
  parameter int STEP_W     = 6,
  parameter int TIME_W     = 8,
  parameter int TICK_DIV   = 100,
  parameter int STEP_LIMIT = 0,
  parameter int TIME_LIMIT = 0
) (
  input  logic              clk_d,
  input  logic              rst,
  input  logic              start_sw,
  input  logic              set_bt,
  input  logic [ACT_N-1:0]  act_bt,
  input  logic              win_flag,
  input  logic              init_done,
  input  logic [OUT_W-1:0]  out_mode_chose,
  input  logic [OUT_W-1:0]  out_mode_game,
  output logic              set_pulse,
  output logic [ACT_N-1:0]  act_pulse,
  output logic [2:0]        game_status,
  output logic [STEP_W-1:0] step_count,
  output logic [TIME_W-1:0] time_sec,
  output logic [OUT_W-1:0]  out
);

  localparam int                 PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0]  STEP_MAX   = {STEP_W{1'b1}};
  localparam logic [TIME_W-1:0]  TIME_MAX   = {TIME_W{1'b1}};
  localparam logic [31:0]        STEP_LIM_U = 32'(STEP_LIMIT);
  localparam logic [31:0]        TIME_LIM_U = 32'(TIME_LIMIT);

  typedef enum logic [2:0] {
    CHOSE_BOARD  = 3'b000,
    GAMING       = 3'b001,
    GAME_INITIAL = 3'b010,
    WINNED       = 3'b011,
    LOST         = 3'b100
  } state_t;

  state_t               state;
  state_t               next_state;
  logic                 set_q;
  logic [ACT_N-1:0]     act_q;
  logic                 set_raw;
  logic [ACT_N-1:0]     act_raw;
  logic [PRESC_W-1:0]   presc;
  logic                 limit_hit;
  logic                 start_game;

  // A chord (several buttons rising together) is not a move.
  function automatic logic [ACT_N-1:0] chord_filter(input logic [ACT_N-1:0] v);
    chord_filter = $onehot(v) ? v : {ACT_N{1'b0}};
  endfunction

  assign game_status = state;
  assign start_game  = (state == CHOSE_BOARD) && start_sw;

  // Sample button levels and register their raw rising edges; sample regs
  // reset to 1 so a button held through reset never produces a pulse.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      set_q   <= 1'b1;
      act_q   <= {ACT_N{1'b1}};
      set_raw <= 1'b0;
      act_raw <= {ACT_N{1'b0}};
    end else begin
      set_raw <= set_bt & ~set_q;
      act_raw <= act_bt & ~act_q;
      set_q   <= set_bt;
      act_q   <= act_bt;
    end
  end

  // Decide whether a configured move or time limit has been reached.
  always_comb begin
    limit_hit = 1'b0;
    if ((STEP_LIMIT != 0) && (32'(step_count) >= STEP_LIM_U)) begin
      limit_hit = 1'b1;
    end else if ((TIME_LIMIT != 0) && (32'(time_sec) >= TIME_LIM_U)) begin
      limit_hit = 1'b1;
    end else begin
      limit_hit = 1'b0;
    end
  end

  // Next-phase logic; dropping start_sw always returns to board selection.
  always_comb begin
    next_state = state;
    case (state)
      CHOSE_BOARD: begin
        if (start_sw) next_state = GAME_INITIAL;
        else          next_state = CHOSE_BOARD;
      end
      GAME_INITIAL: begin
        if (!start_sw)      next_state = CHOSE_BOARD;
        else if (init_done) next_state = GAMING;
        else                next_state = GAME_INITIAL;
      end
      GAMING: begin
        if (!start_sw)      next_state = CHOSE_BOARD;
        else if (win_flag)  next_state = WINNED;
        else if (limit_hit) next_state = LOST;
        else                next_state = GAMING;
      end
      WINNED: begin
        if (!start_sw) next_state = CHOSE_BOARD;
        else           next_state = WINNED;
      end
      LOST: begin
        if (!start_sw) next_state = CHOSE_BOARD;
        else           next_state = LOST;
      end
      default: next_state = CHOSE_BOARD;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk_d) begin
    if (rst) state <= CHOSE_BOARD;
    else     state <= next_state;
  end

  // Pulse outputs, gated by the phase the pulse cycle will be in so a
  // pulse never appears outside its owning phase.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      set_pulse <= 1'b0;
      act_pulse <= {ACT_N{1'b0}};
    end else begin
      set_pulse <= set_raw & (next_state == CHOSE_BOARD);
      act_pulse <= (next_state == GAMING) ? chord_filter(act_raw) : {ACT_N{1'b0}};
    end
  end

  // Move counter: cleared on game start, saturating, frozen outside GAMING.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      step_count <= {STEP_W{1'b0}};
    end else if (start_game) begin
      step_count <= {STEP_W{1'b0}};
    end else if ((state == GAMING) && (act_pulse != {ACT_N{1'b0}}) &&
                 (step_count != STEP_MAX)) begin
      step_count <= step_count + STEP_W'(1);
    end else begin
      step_count <= step_count;
    end
  end

  // One-second time base: prescaler plus saturating seconds counter.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      presc    <= {PRESC_W{1'b0}};
      time_sec <= {TIME_W{1'b0}};
    end else if (start_game) begin
      presc    <= {PRESC_W{1'b0}};
      time_sec <= {TIME_W{1'b0}};
    end else if (state == GAMING) begin
      if (presc == PRESC_LAST) begin
        presc <= {PRESC_W{1'b0}};
        if (time_sec != TIME_MAX) time_sec <= time_sec + TIME_W'(1);
        else                      time_sec <= time_sec;
      end else begin
        presc    <= presc + PRESC_W'(1);
        time_sec <= time_sec;
      end
    end else begin
      presc    <= presc;
      time_sec <= time_sec;
    end
  end

  // Registered display mux selected by the current phase.
  always_ff @(posedge clk_d) begin
    if (rst)                        out <= {OUT_W{1'b0}};
    else if (state == CHOSE_BOARD)  out <= out_mode_chose;
    else                            out <= out_mode_game;
  end

endmodule

// File: tb/tb_game_ctrl_gen.sv
// tb_game_ctrl_gen: two differently configured controllers driven by the same
// stimulus, each checked every cycle against a phase-level reference model.
module tb_game_ctrl_gen;

  logic        clk_d = 1'b0;
  logic        rst, start_sw, set_bt, win_flag, init_done;
  logic [3:0]  act_bt;
  logic [11:0] out_mode_chose, out_mode_game;

  logic        set_a, set_b;
  logic [3:0]  act_a, act_b;
  logic [2:0]  st_a, st_b;
  logic [5:0]  step_a;
  logic [2:0]  step_b;
  logic [3:0]  time_a;
  logic [7:0]  time_b;
  logic [11:0] out_a, out_b;

  int n_cmp = 0;
  int n_bad = 0;

  // model configuration: index 0 = dut_a, 1 = dut_b
  int p_slim[2] = '{3, 0};
  int p_tlim[2] = '{0, 2};
  int p_tick[2] = '{5, 4};
  int p_smax[2] = '{63, 7};
  int p_tmax[2] = '{15, 255};

  // model state
  int         m_ph[2], m_step[2], m_time[2], m_presc[2];
  logic [3:0] m_act[2], m_rawact[2], m_prevact[2];
  logic       m_set[2], m_rawset[2], m_prevset[2];
  logic [11:0] m_out[2];

  always #5 clk_d = ~clk_d;

  game_ctrl_gen #(.ACT_N(4), .OUT_W(12), .STEP_W(6), .TIME_W(4), .TICK_DIV(5),
                  .STEP_LIMIT(3), .TIME_LIMIT(0)) dut_a (
    .clk_d(clk_d), .rst(rst), .start_sw(start_sw), .set_bt(set_bt), .act_bt(act_bt),
    .win_flag(win_flag), .init_done(init_done), .out_mode_chose(out_mode_chose),
    .out_mode_game(out_mode_game), .set_pulse(set_a), .act_pulse(act_a),
    .game_status(st_a), .step_count(step_a), .time_sec(time_a), .out(out_a));

  game_ctrl_gen #(.ACT_N(4), .OUT_W(12), .STEP_W(3), .TIME_W(8), .TICK_DIV(4),
                  .STEP_LIMIT(0), .TIME_LIMIT(2)) dut_b (
    .clk_d(clk_d), .rst(rst), .start_sw(start_sw), .set_bt(set_bt), .act_bt(act_bt),
    .win_flag(win_flag), .init_done(init_done), .out_mode_chose(out_mode_chose),
    .out_mode_game(out_mode_game), .set_pulse(set_b), .act_pulse(act_b),
    .game_status(st_b), .step_count(step_b), .time_sec(time_b), .out(out_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, advanced once per rising edge with the inputs seen there.
  // Phases: 0 choose, 1 playing, 2 loading, 3 won, 4 lost.
  task automatic mdl(input int i);
    int  ph, nph;
    bit  lim;
    if (rst) begin
      m_ph[i] = 0; m_step[i] = 0; m_time[i] = 0; m_presc[i] = 0;
      m_act[i] = 4'h0; m_set[i] = 1'b0; m_out[i] = 12'h000;
      m_rawact[i] = 4'h0; m_rawset[i] = 1'b0;
      m_prevact[i] = 4'hF; m_prevset[i] = 1'b1;
      return;
    end
    ph  = m_ph[i];
    lim = (p_slim[i] != 0 && m_step[i] >= p_slim[i]) ||
          (p_tlim[i] != 0 && m_time[i] >= p_tlim[i]);
    if (ph == 0)           nph = start_sw ? 2 : 0;
    else if (!start_sw)    nph = 0;
    else if (ph == 2)      nph = init_done ? 1 : 2;
    else if (ph == 1)      nph = win_flag ? 3 : (lim ? 4 : 1);
    else                   nph = ph;
    m_out[i] = (ph == 0) ? out_mode_chose : out_mode_game;
    if (ph == 0 && start_sw) begin
      m_step[i] = 0; m_time[i] = 0; m_presc[i] = 0;
    end else if (ph == 1) begin
      if (m_act[i] != 4'h0 && m_step[i] < p_smax[i]) m_step[i]++;
      m_presc[i]++;
      if (m_presc[i] == p_tick[i]) begin
        m_presc[i] = 0;
        if (m_time[i] < p_tmax[i]) m_time[i]++;
      end
    end
    m_act[i] = (nph == 1 && $countones(m_rawact[i]) == 1) ? m_rawact[i] : 4'h0;
    m_set[i] = (nph == 0) ? m_rawset[i] : 1'b0;
    m_rawact[i]  = act_bt & ~m_prevact[i];
    m_rawset[i]  = set_bt & ~m_prevset[i];
    m_prevact[i] = act_bt;
    m_prevset[i] = set_bt;
    m_ph[i] = nph;
  endtask

  task automatic compare_all();
    chk("a_status", 32'(st_a),   32'(m_ph[0]));
    chk("a_step",   32'(step_a), 32'(m_step[0]));
    chk("a_time",   32'(time_a), 32'(m_time[0]));
    chk("a_act",    32'(act_a),  32'(m_act[0]));
    chk("a_set",    32'(set_a),  32'(m_set[0]));
    chk("a_out",    32'(out_a),  32'(m_out[0]));
    chk("b_status", 32'(st_b),   32'(m_ph[1]));
    chk("b_step",   32'(step_b), 32'(m_step[1]));
    chk("b_time",   32'(time_b), 32'(m_time[1]));
    chk("b_act",    32'(act_b),  32'(m_act[1]));
    chk("b_set",    32'(set_b),  32'(m_set[1]));
    chk("b_out",    32'(out_b),  32'(m_out[1]));
  endtask

  task automatic tick();
    @(posedge clk_d);
    mdl(0);
    mdl(1);
    @(negedge clk_d);
    compare_all();
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start_sw = 1'b0; set_bt = 1'b0; win_flag = 1'b0; init_done = 1'b0;
    act_bt = 4'b0001; out_mode_chose = 12'h000; out_mode_game = 12'h000;

    // reset with act_bt[0] held, then idle
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_state_a", 32'(st_a), 32'd0);
    chk("rst_act_a",   32'(act_a), 32'd0);
    chk("rst_out_a",   32'(out_a), 32'd0);
    chk("rst_state_b", 32'(st_b), 32'd0);

    // start, load, play: act_bt[2] held five cycles
    act_bt = 4'b0000; out_mode_game = 12'h5A5;
    start_sw = 1'b1;
    tick();
    chk("enter_init", 32'(st_a), 32'd2);
    repeat (2) tick();
    init_done = 1'b1;
    tick();
    chk("enter_gaming", 32'(st_a), 32'd1);
    init_done = 1'b0;
    pulses = 0;
    for (int j = 1; j <= 12; j++) begin
      act_bt = (j <= 5) ? 4'b0100 : 4'b0000;
      tick();
      if (act_a == 4'b0100) pulses++;
      if (j == 4) chk("b_time_1s", 32'(time_b), 32'd1);
      if (j == 8) chk("b_time_2s", 32'(time_b), 32'd2);
      if (j == 9) chk("b_time_lost", 32'(st_b), 32'd4);
    end
    chk("a_single_pulse", 32'(pulses), 32'd1);
    chk("a_step_one", 32'(step_a), 32'd1);

    // chord is rejected
    act_bt = 4'b0011;
    repeat (3) tick();
    act_bt = 4'b0000;
    repeat (3) tick();
    chk("chord_no_step", 32'(step_a), 32'd1);

    // step limit of three on dut_a
    for (int p = 0; p < 2; p++) begin
      act_bt = 4'b0010; tick();
      act_bt = 4'b0000; repeat (3) tick();
    end
    chk("step_lim_cnt", 32'(step_a), 32'd3);
    chk("step_lim_lost", 32'(st_a), 32'd4);
    for (int p = 0; p < 2; p++) begin
      act_bt = 4'b1000; tick();
      act_bt = 4'b0000; repeat (3) tick();
    end
    chk("lost_frozen", 32'(step_a), 32'd3);

    // new game; win on the very cycle dut_b's time limit is hit
    start_sw = 1'b0; tick();
    start_sw = 1'b1; tick();
    init_done = 1'b1; tick();
    init_done = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      act_bt = (j == 1) ? 4'b1000 : 4'b0000;
      tick();
    end
    win_flag = 1'b1; tick();
    win_flag = 1'b0;
    chk("win_beats_limit", 32'(st_b), 32'd3);
    chk("a_won", 32'(st_a), 32'd3);

    // back to board selection: out follows one cycle later, count held
    out_mode_chose = 12'hA5C; out_mode_game = 12'h3C3;
    start_sw = 1'b0; tick();
    chk("back_to_chose", 32'(st_a), 32'd0);
    chk("out_lag", 32'(out_a), 32'h3C3);
    tick();
    chk("out_chose", 32'(out_a), 32'hA5C);
    chk("step_held", 32'(step_a), 32'd1);

    // randomized play
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 59) == 0) start_sw = ~start_sw;
      init_done = ($urandom_range(0, 7) == 0);
      win_flag  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) set_bt = ~set_bt;
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0, 1:    act_bt = 4'b0000;
          2, 3, 4: act_bt = 4'b0001 << $urandom_range(0, 3);
          default: act_bt = 4'($urandom_range(0, 15));
        endcase
      end
      out_mode_chose = 12'($urandom_range(0, 4095));
      out_mode_game  = 12'($urandom_range(0, 4095));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
